// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: baud timing constants, the defaults for the
// transmit arbiter (requester count, completion watchdog length), the
// arbiter state encoding and a small helper for index widths.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int CLK_FREQ_HZ  = 100_000_000;
  localparam int BAUD_RATE    = 115_200;
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  localparam int ARB_N_REQ_DEFAULT       = 4;
  localparam int ARB_TIMEOUT_CYC_DEFAULT = 131072;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // A single requester still needs a 1-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side and the uart_tx side of the transmit arbiter.
//   req, req_data   : per-requester level request and byte (byte i at [8i+7:8i])
//   ack             : one-cycle accept pulse, one bit per requester
//   tx_start/tx_data: start strobe and byte towards uart_tx
//   tx_done         : stop-bit-complete pulse from uart_tx
//   grant_id, busy, timeout_err : status
// Modports: master = environment (requesters + uart_tx), slave = arbiter.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ_DEFAULT
);

  localparam int IDW = idx_width(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic               timeout_err;

  modport master (
    output req, req_data, tx_done,
    input  ack, tx_start, tx_data, grant_id, busy, timeout_err
  );

  modport slave (
    input  req, req_data, tx_done,
    output ack, tx_start, tx_data, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority search: returns the first set bit of req
// scanning upward from rr_ptr, wrapping from N_REQ-1 back to 0.
//   req    : request vector
//   rr_ptr : index with highest priority this round
//   found  : any request present
//   index  : selected requester (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ_DEFAULT,
  localparam int IDW  = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic             found,
  output logic [IDW-1:0]   index
);

  // Walk the offsets from farthest to nearest so the nearest hit to rr_ptr
  // is the last assignment and therefore wins.
  always_comb begin
    int               cand;
    logic [N_REQ-1:0] shifted;
    found   = |req;
    index   = '0;
    cand    = 0;
    shifted = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand    = (int'(rr_ptr) + off) % N_REQ;
      shifted = req >> cand;
      if (shifted[0]) begin
        index = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter letting N_REQ requesters share one uart_tx. A grant
// latches the byte, pulses ack for the winner, strobes tx_start for one cycle
// and then waits for tx_done, guarded by a watchdog of TIMEOUT_CYC cycles.
//   clk : system clock, all logic on its rising edge
//   rst : synchronous active-high reset, aborts any transfer in flight
//   bus : uart_tx_arbiter_if.slave (requests, acks, uart_tx handshake, status)
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = ARB_N_REQ_DEFAULT,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IDW = idx_width(N_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYC - 1);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             timeout_err_q, timeout_err_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_index;
  logic [IDW-1:0]   next_ptr;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_index)
  );

  // Priority moves to the requester just after the one last served, whether
  // its transfer completed or was aborted by the watchdog.
  assign next_ptr = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      wdog_q        <= '0;
      ack_q         <= '0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
      ack_q         <= ack_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // tx_done only matters in WAIT; a done arriving on the watchdog's last
  // cycle is taken as a normal completion.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    wdog_d        = wdog_q;
    ack_d         = '0;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          tx_data_d  = 8'(bus.req_data >> (8 * int'(pick_index)));
          grant_id_d = pick_index;
          ack_d      = N_REQ'(1) << pick_index;
          state_d    = START;
        end
      end
      START: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else if (wdog_q == WD_LAST) begin
          rr_ptr_d      = next_ptr;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ack         = ack_q;
  assign bus.tx_start    = (state_q == START);
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. Two instances: one with a long
// watchdog for the normal transfer scenarios, one with TIMEOUT_CYC=16 for the
// watchdog scenarios. Expected grants come from a round-robin reference model
// (first set request at or after the priority pointer, modulo N).
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NQ = 4;

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.N_REQ(NQ)) bus ();
  uart_tx_arbiter_if #(.N_REQ(NQ)) bus16 ();

  uart_tx_arbiter #(.N_REQ(NQ), .TIMEOUT_CYC(131072)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  uart_tx_arbiter #(.N_REQ(NQ), .TIMEOUT_CYC(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  int checks = 0;
  int passes = 0;
  int ptr    = 0;
  int ptr16  = 0;
  logic [7:0] data [NQ];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: first requester at or after p, wrapping modulo NQ.
  function automatic int model_pick(input logic [NQ-1:0] r, input int p);
    for (int k = 0; k < NQ; k++) begin
      if (r[(p + k) % NQ]) return (p + k) % NQ;
    end
    return -1;
  endfunction

  function automatic logic [NQ*8-1:0] packed_data();
    return {data[3], data[2], data[1], data[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_data();
    for (int i = 0; i < NQ; i++) data[i] = 8'($urandom);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack == '0 && n < 50);
  endtask

  task automatic test_reset();
    bus.req = '0;   bus.req_data = '0;   bus.tx_done = 1'b0;
    bus16.req = '0; bus16.req_data = '0; bus16.tx_done = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.ack !== 4'b0) $display("[TB] FAIL reset_ack got %b expected 0000", bus.ack); else passes++;
    checks++; if (bus.tx_start !== 1'b0) $display("[TB] FAIL reset_tx_start got %b expected 0", bus.tx_start); else passes++;
    checks++; if (bus.tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data got %h expected 00", bus.tx_data); else passes++;
    checks++; if (bus.grant_id !== 2'd0) $display("[TB] FAIL reset_grant_id got %0d expected 0", bus.grant_id); else passes++;
    checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0)
      $display("[TB] FAIL reset_status got busy=%b terr=%b expected 0/0", bus.busy, bus.timeout_err); else passes++;
    checks++; if (bus16.busy !== 1'b0 || bus16.ack !== 4'b0)
      $display("[TB] FAIL reset_dut16 got busy=%b ack=%b expected 0/0000", bus16.busy, bus16.ack); else passes++;
  endtask

  task automatic test_single();
    new_data();
    data[2] = 8'hA5;
    bus.req_data = packed_data();
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.ack !== 4'b0100) $display("[TB] FAIL single_ack got %b expected 0100", bus.ack); else passes++;
    checks++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5)
      $display("[TB] FAIL single_start got start=%b data=%h expected 1/a5", bus.tx_start, bus.tx_data); else passes++;
    checks++; if (bus.grant_id !== 2'd2 || bus.busy !== 1'b1)
      $display("[TB] FAIL single_grant got id=%0d busy=%b expected 2/1", bus.grant_id, bus.busy); else passes++;
    bus.req = '0;
    tick();
    checks++; if (bus.tx_start !== 1'b0 || bus.ack !== 4'b0)
      $display("[TB] FAIL single_pulse_width got start=%b ack=%b expected 0/0000", bus.tx_start, bus.ack); else passes++;
    repeat (998) tick();
    checks++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0)
      $display("[TB] FAIL single_wait got busy=%b terr=%b expected 1/0", bus.busy, bus.timeout_err); else passes++;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.tx_data !== 8'hA5 || bus.grant_id !== 2'd2)
      $display("[TB] FAIL single_done got busy=%b data=%h id=%0d expected 0/a5/2", bus.busy, bus.tx_data, bus.grant_id); else passes++;
    ptr = 3;
  endtask

  task automatic test_ignored_done();
    int g;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0)
      $display("[TB] FAIL done_in_idle got busy=%b ack=%b expected 0/0000", bus.busy, bus.ack); else passes++;
    new_data();
    bus.req_data = packed_data();
    bus.req = 4'b0001;
    tick();
    g = model_pick(4'b0001, ptr);
    checks++; if (bus.ack !== 4'(1 << g) || bus.grant_id !== 2'(g) || bus.tx_start !== 1'b1)
      $display("[TB] FAIL ign_grant got ack=%b id=%0d expected ack=%b id=%0d", bus.ack, bus.grant_id, 4'(1 << g), g); else passes++;
    bus.req = '0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0)
      $display("[TB] FAIL done_in_start got busy=%b start=%b expected 1/0", bus.busy, bus.tx_start); else passes++;
    tick();
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL still_waiting got busy=%b expected 1", bus.busy); else passes++;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL done_in_wait got busy=%b expected 0", bus.busy); else passes++;
    ptr = (g + 1) % NQ;
  endtask

  task automatic test_fairness();
    int g;
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr = 0;
    new_data();
    bus.req_data = packed_data();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      g = model_pick(4'b1111, ptr);
      checks++; if (n != 1) $display("[TB] FAIL fair_latency got %0d cycles expected 1", n); else passes++;
      checks++; if (bus.ack !== 4'(1 << g) || bus.grant_id !== 2'(g) || bus.tx_data !== data[g] || bus.tx_start !== 1'b1)
        $display("[TB] FAIL fair_grant%0d got ack=%b id=%0d data=%h expected ack=%b id=%0d data=%h",
                 k, bus.ack, bus.grant_id, bus.tx_data, 4'(1 << g), g, data[g]); else passes++;
      if (k == 4) bus.req = '0;
      repeat (19) tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      ptr = (g + 1) % NQ;
    end
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL fair_end got busy=%b expected 0", bus.busy); else passes++;
  endtask

  task automatic test_wrap();
    int g;
    int n;
    new_data();
    bus.req_data = packed_data();
    bus.req = 4'b0100;
    tick();
    g = model_pick(4'b0100, ptr);
    checks++; if (bus.grant_id !== 2'(g)) $display("[TB] FAIL wrap_pre got id=%0d expected %0d", bus.grant_id, g); else passes++;
    bus.req = '0;
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    ptr = (g + 1) % NQ;
    bus.req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      wait_ack(n);
      g = model_pick(4'b1001, ptr);
      checks++; if (bus.ack !== 4'(1 << g) || bus.grant_id !== 2'(g) || n != 1)
        $display("[TB] FAIL wrap_grant%0d got ack=%b id=%0d lat=%0d expected ack=%b id=%0d lat=1",
                 k, bus.ack, bus.grant_id, n, 4'(1 << g), g); else passes++;
      if (k == 1) bus.req = '0;
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      ptr = (g + 1) % NQ;
    end
  endtask

  task automatic test_timeout();
    int g;
    int bad;
    new_data();
    bus16.req_data = packed_data();
    bus16.req = 4'b0010;
    tick();
    g = model_pick(4'b0010, ptr16);
    checks++; if (bus16.ack !== 4'(1 << g) || bus16.grant_id !== 2'(g))
      $display("[TB] FAIL to_grant got ack=%b id=%0d expected ack=%b id=%0d", bus16.ack, bus16.grant_id, 4'(1 << g), g); else passes++;
    bus16.req = '0;
    bad = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus16.busy !== 1'b1 || bus16.timeout_err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("[TB] FAIL to_wait16 got %0d bad WAIT cycles expected 0", bad); else passes++;
    tick();
    checks++; if (bus16.timeout_err !== 1'b1 || bus16.busy !== 1'b0)
      $display("[TB] FAIL to_pulse got terr=%b busy=%b expected 1/0", bus16.timeout_err, bus16.busy); else passes++;
    tick();
    checks++; if (bus16.timeout_err !== 1'b0) $display("[TB] FAIL to_once got terr=%b expected 0", bus16.timeout_err); else passes++;
    ptr16 = (g + 1) % NQ;
    bus16.req = 4'b1111;
    tick();
    g = model_pick(4'b1111, ptr16);
    checks++; if (bus16.grant_id !== 2'(g) || bus16.ack !== 4'(1 << g))
      $display("[TB] FAIL to_next_grant got id=%0d ack=%b expected id=%0d", bus16.grant_id, bus16.ack, g); else passes++;
    bus16.req = '0;
    repeat (16) tick();
    bus16.tx_done = 1'b1;
    tick();
    bus16.tx_done = 1'b0;
    checks++; if (bus16.busy !== 1'b0 || bus16.timeout_err !== 1'b0)
      $display("[TB] FAIL to_tie got busy=%b terr=%b expected 0/0", bus16.busy, bus16.timeout_err); else passes++;
    ptr16 = (g + 1) % NQ;
  endtask

  task automatic test_reset_mid();
    int g;
    new_data();
    bus.req_data = packed_data();
    bus.req = 4'b0001;
    tick();
    g = model_pick(4'b0001, ptr);
    checks++; if (bus.ack !== 4'(1 << g)) $display("[TB] FAIL rstmid_grant got ack=%b expected %b", bus.ack, 4'(1 << g)); else passes++;
    bus.req = '0;
    tick();
    rst = 1'b1;
    bus.req = 4'b1111;
    tick();
    checks++; if ({bus.ack, bus.tx_start, bus.tx_data, bus.grant_id, bus.busy, bus.timeout_err} !== 17'b0)
      $display("[TB] FAIL rstmid_outputs got ack=%b st=%b data=%h id=%0d busy=%b terr=%b expected all 0",
               bus.ack, bus.tx_start, bus.tx_data, bus.grant_id, bus.busy, bus.timeout_err); else passes++;
    tick();
    checks++; if (bus.ack !== 4'b0 || bus.busy !== 1'b0)
      $display("[TB] FAIL rst_override got ack=%b busy=%b expected 0000/0", bus.ack, bus.busy); else passes++;
    rst = 1'b0;
    bus.req = '0;
    ptr = 0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0 || bus.tx_start !== 1'b0)
      $display("[TB] FAIL stale_done got busy=%b ack=%b st=%b expected 0/0000/0", bus.busy, bus.ack, bus.tx_start); else passes++;
    bus.req = 4'b1001;
    tick();
    g = model_pick(4'b1001, ptr);
    checks++; if (bus.grant_id !== 2'(g)) $display("[TB] FAIL rstmid_ptr got id=%0d expected %0d", bus.grant_id, g); else passes++;
    bus.req = '0;
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    ptr = (g + 1) % NQ;
  endtask

  task automatic test_random();
    int g;
    int d;
    logic [NQ-1:0] r;
    for (int it = 0; it < 24; it++) begin
      r = 4'($urandom_range(1, 15));
      new_data();
      bus.req_data = packed_data();
      bus.req = r;
      tick();
      g = model_pick(r, ptr);
      checks++; if ({bus.ack, bus.tx_start, bus.grant_id, bus.tx_data} !== {4'(1 << g), 1'b1, 2'(g), data[g]})
        $display("[TB] FAIL rand_grant%0d req=%b got ack=%b id=%0d data=%h expected ack=%b id=%0d data=%h",
                 it, r, bus.ack, bus.grant_id, bus.tx_data, 4'(1 << g), g, data[g]); else passes++;
      bus.req = 4'($urandom);
      tick();
      d = $urandom_range(0, 6);
      repeat (d) tick();
      checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'(g) || bus.tx_data !== data[g])
        $display("[TB] FAIL rand_stable%0d got busy=%b id=%0d data=%h expected 1/%0d/%h",
                 it, bus.busy, bus.grant_id, bus.tx_data, g, data[g]); else passes++;
      bus.req = '0;
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL rand_done%0d got busy=%b expected 0", it, bus.busy); else passes++;
      ptr = (g + 1) % NQ;
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_ignored_done();
    test_fairness();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout got no completion expected finish before 1ms");
    $fatal(1, "[TB] run did not complete");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one uart_tx.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 131072: clk cycles allowed from tx_start to tx_done before abort.
REQ-003 SHALL have port clk  input  1  system clock (100 MHz); one clock, all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req  input  N_REQ  per-requester send request; level, held until ack.
REQ-006 SHALL have port req_data  input  N_REQ*8  byte of requester i at bits [8i+7:8i]; stable while req[i]=1.
REQ-007 SHALL have port ack  output  N_REQ  one-cycle pulse: byte of requester i accepted.
REQ-008 SHALL have port tx_start  output  1  start strobe to uart_tx.
REQ-009 SHALL have port tx_data  output  8  byte to uart_tx; valid while tx_start=1.
REQ-010 SHALL have port tx_done  input  1  one-cycle pulse from uart_tx when the stop bit completes.
REQ-011 SHALL have port grant_id  output  clog2(N_REQ)  index of the current or last granted requester.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT; all outputs registered or decoded from state registers only.
REQ-015 SHALL, in IDLE with req!=0, select the first set req bit scanning upward from rr_ptr with wrap from N_REQ-1 to 0.
REQ-016 SHALL, on that IDLE edge, latch tx_data<=selected byte, grant_id<=index, ack[index]<=1 (only that bit), state<=START.
REQ-017 SHALL drive tx_start=1 for exactly the single cycle spent in START, then enter WAIT with watchdog counter cleared.
REQ-018 SHALL, in WAIT, on tx_done=1 set rr_ptr<=grant_id+1 mod N_REQ and return to IDLE.
REQ-019 SHALL ignore tx_done in IDLE and START.
REQ-020 SHALL, in WAIT, increment the watchdog each cycle; on reaching TIMEOUT_CYC-1 without tx_done, pulse timeout_err, advance rr_ptr as in REQ-018, and return to IDLE.
REQ-021 SHALL treat tx_done and watchdog expiry in the same cycle as a normal completion (no timeout_err).
REQ-022 SHALL give a latency of 1 cycle from req sampled in IDLE to ack and tx_start; minimum period per byte is 3 cycles plus uart_tx time.
REQ-023 SHALL NOT grant a requester whose req drops before it is sampled in IDLE; req changes after the grant edge SHALL NOT affect the transfer in flight.
REQ-024 SHALL keep tx_data and grant_id stable from the grant edge until the next grant.
REQ-025 SHALL guarantee that every continuously asserting requester is granted within N_REQ transfers.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, set state=IDLE, rr_ptr=0, watchdog=0, ack=0, tx_start=0, tx_data=0, grant_id=0, busy=0, timeout_err=0.
REQ-027 SHALL treat rst during START or WAIT as an abort: no ack or tx_start afterwards for that byte, and rst overrides all other inputs.

Structure
REQ-028 SHALL take state encoding, the default N_REQ, and the TIMEOUT_CYC default from shared package uart_pkg, alongside the existing baud constants.
REQ-029 SHALL place the rotate-priority search in one combinational sub-module rr_pick (inputs req, rr_ptr; outputs found, index).

Verification
REQ-030 Single request: req=4'b0100, req_data byte2=8'hA5, then tx_done 1000 cycles later -> ack=4'b0100 and tx_start one cycle later, tx_data=8'hA5, grant_id=2, busy low after tx_done.
REQ-031 Fairness: req=4'b1111 held, tx_done 20 cycles after each tx_start -> grant order 0,1,2,3,0; ack bits hot-one in the same order.
REQ-032 Wrap: rr_ptr=3 after a grant to 2, req=4'b1001 -> grant 3, then 0.
REQ-033 Timeout: TIMEOUT_CYC=16, grant to 1, no tx_done -> timeout_err pulses exactly once at WAIT cycle 16, IDLE next, next grant starts search at 2.
REQ-034 Reset mid-operation: rst asserted the cycle after tx_start -> all outputs at reset values next edge; a stale tx_done pulse afterwards causes no state change.
REQ-035 Ignored done: tx_done pulsed in IDLE and in START -> no state change; completion occurs only on a tx_done seen in WAIT.
